// File: rtl/seq_signed_or_unsigned_mul.sv
`default_nettype none
// ============================================================================
//  Module      : seq_signed_or_unsigned_mul
//  Description : Iterative shift-add multiplier. One N-bit adder is reused over
//                N cycles to build a 2N-bit product, LSB of the multiplier
//                first. Each operation selects signed (two's complement) or
//                unsigned operands. Signed operation works on magnitudes and
//                negates the product at the end.
//                Valid/ready handshake on the operand and result sides.
//
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                in_valid   - operand request
//                in_ready   - block idle, can accept operands
//                a, b       - multiplicand / multiplier, N bits
//                sign       - 1: two's-complement operands and result
//                out_valid  - res holds a finished product
//                out_ready  - consumer accepts res
//                res        - 2N-bit product
//
//  Options     : SEQ_MUL_ZERO_SKIP_EN - when defined, a zero operand bypasses
//                the iteration and the zero product is ready one cycle after
//                acceptance.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_signed_or_unsigned_mul #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           sign,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] res
);

    localparam int c_cnt_w = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [N-1:0]         mcand_q,     mcand_d;
    // Upper half: running partial sum. Lower half: remaining multiplier bits,
    // shifted out on the right as product bits are shifted in from the left.
    logic [2*N-1:0]       acc_q,       acc_d;
    logic [c_cnt_w-1:0]   cnt_q,       cnt_d;
    logic                 neg_q,       neg_d;
    logic [2*N-1:0]       res_q,       res_d;
    logic                 out_valid_q, out_valid_d;

    logic [N:0]           w_sum;
    logic [2*N-1:0]       w_acc_shift;
    logic [N-1:0]         w_a_mag;
    logic [N-1:0]         w_b_mag;

    // Magnitudes for signed mode. The most-negative value negates to itself,
    // which read as unsigned is exactly 2^(N-1), so no extra bit is needed.
    assign w_a_mag = (sign && a[N-1]) ? -a : a;
    assign w_b_mag = (sign && b[N-1]) ? -b : b;

    // The single N-bit adder, with carry kept as the new top bit.
    assign w_sum       = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
    assign w_acc_shift = {w_sum, acc_q[N-1:1]};

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d = w_a_mag;
                    acc_d   = {{N{1'b0}}, w_b_mag};
                    neg_d   = sign & (a[N-1] ^ b[N-1]);
                    cnt_d   = c_cnt_w'(N);
                    state_d = S_BUSY;
`ifdef SEQ_MUL_ZERO_SKIP_EN
                    if ((a == {N{1'b0}}) || (b == {N{1'b0}})) begin
                        res_d       = {(2*N){1'b0}};
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
`endif
                end
            end

            S_BUSY: begin
                acc_d = w_acc_shift;
                cnt_d = cnt_q - c_cnt_w'(1);
                // Last iteration: the shifted accumulator is the full magnitude.
                if (cnt_q == c_cnt_w'(1)) begin
                    res_d       = neg_q ? -w_acc_shift : w_acc_shift;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                // res is intentionally left alone; only the next result replaces it.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= {N{1'b0}};
            acc_q       <= {(2*N){1'b0}};
            cnt_q       <= {c_cnt_w{1'b0}};
            neg_q       <= 1'b0;
            res_q       <= {(2*N){1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign res       = res_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_signed_or_unsigned_mul.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_signed_or_unsigned_mul
//  Description : Self-checking bench for seq_signed_or_unsigned_mul at N=4.
//                Directed vector table, exhaustive signed/unsigned sweep,
//                backpressure, asynchronous reset mid-operation and zero
//                operand latency (SEQ_MUL_ZERO_SKIP_EN aware).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_signed_or_unsigned_mul;

    localparam int N = 4;
`ifdef SEQ_MUL_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = N;
`endif
    localparam int MAXWAIT = 40;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           sign;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] res;

    int errors = 0;
    int checks = 0;

    seq_signed_or_unsigned_mul #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic           sign;
        logic [2*N-1:0] exp;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until out_valid is seen, bounded.
    task automatic wait_out(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!out_valid && k < MAXWAIT);
    endtask

    // Full transaction: present operands, check latency and product, consume.
    task automatic run_op(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic ts, input logic [2*N-1:0] exp, input int exp_lat);
        int k;
        in_valid = 1'b1; a = ta; b = tb; sign = ts;
        chk({name, " in_ready"}, int'(in_ready), 1);
        tick();                                  // accepting edge T
        in_valid = 1'b0;
        a = N'($urandom); b = N'($urandom); sign = 1'($urandom);
        wait_out(k);
        chk({name, " latency"}, k, exp_lat);
        chk({name, " res"}, int'(res), int'(exp));
        chk({name, " in_ready busy"}, int'(in_ready), 0);
        out_ready = 1'b1;
        tick();                                  // consumption edge
        out_ready = 1'b0;
        chk({name, " out_valid drop"}, int'(out_valid), 0);
        chk({name, " in_ready back"}, int'(in_ready), 1);
    endtask

    initial begin
        int k;
        int seen;
        logic [2*N-1:0]        pu;
        logic signed [2*N-1:0] ps;
        logic [N-1:0]          ta;
        logic [N-1:0]          tb;

        vecs[0]  = '{4'd15, 4'd15, 1'b0, 8'hE1};
        vecs[1]  = '{4'h8,  4'h8,  1'b1, 8'h40};
        vecs[2]  = '{4'h8,  4'h7,  1'b1, 8'hC8};
        vecs[3]  = '{4'hF,  4'hF,  1'b1, 8'h01};
        vecs[4]  = '{4'd3,  4'd5,  1'b0, 8'h0F};
        vecs[5]  = '{4'h7,  4'hF,  1'b1, 8'hF9};
        vecs[6]  = '{4'h8,  4'hF,  1'b1, 8'h08};
        vecs[7]  = '{4'h8,  4'h8,  1'b0, 8'h40};
        vecs[8]  = '{4'h8,  4'h1,  1'b1, 8'hF8};
        vecs[9]  = '{4'h5,  4'hD,  1'b1, 8'hF1};
        vecs[10] = '{4'd9,  4'd9,  1'b0, 8'h51};
        vecs[11] = '{4'd2,  4'd3,  1'b0, 8'h06};
        vecs[12] = '{4'd0,  4'd11, 1'b0, 8'h00};
        vecs[13] = '{4'hF,  4'h0,  1'b1, 8'h00};
        vecs[14] = '{4'hF,  4'h1,  1'b0, 8'h0F};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sign = 1'b0;
        tick();
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset res", int'(res), 0);
        #2 rst_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sign, vecs[i].exp,
                   (vecs[i].a == 0 || vecs[i].b == 0) ? ZLAT : N);
        end

        // Exhaustive sweep, both signedness modes
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    ta = N'(i); tb = N'(j);
                    pu = ta * tb;
                    ps = $signed(ta) * $signed(tb);
                    run_op($sformatf("sweep s%0d %0d*%0d", s, i, j), ta, tb, s[0],
                           s[0] ? ps : pu, (i == 0 || j == 0) ? ZLAT : N);
                end
            end
        end

        // Backpressure: result held, new request ignored until after consumption
        in_valid = 1'b1; a = 4'd3; b = 4'd5; sign = 1'b0;
        tick();
        a = 4'd2; b = 4'd7;                      // stays requested through DONE
        wait_out(k);
        chk("bp latency", k, N);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp res hold", int'(res), 8'h0F);
            chk("bp out_valid hold", int'(out_valid), 1);
            chk("bp in_ready low", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();                                  // consumption edge, not acceptance
        out_ready = 1'b0;
        chk("bp consumed", int'(out_valid), 0);
        chk("bp idle", int'(in_ready), 1);
        chk("bp res kept", int'(res), 8'h0F);
        tick();                                  // acceptance edge
        in_valid = 1'b0;
        chk("bp accepted", int'(in_ready), 0);
        wait_out(k);
        chk("bp2 latency", k, N);
        chk("bp2 res", int'(res), 8'h0E);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp2 consumed", int'(in_ready), 1);

        // Asynchronous reset in the middle of BUSY
        in_valid = 1'b1; a = 4'd9; b = 4'd9; sign = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy out_valid", int'(out_valid), 0);
        chk("rst busy res", int'(res), 0);
        chk("rst busy in_ready", int'(in_ready), 1);
        tick();
        #2 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("rst no stale out", seen, 0);
        chk("rst idle", int'(in_ready), 1);
        run_op("post reset", 4'd2, 4'd3, 1'b0, 8'h06, N);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
